inv_pipe: RTL and testbench



---
 rtl/inv_pkg.sv | 49 ++++
 rtl/inv_stage.sv | 29 ++
 rtl/inv_pipe.sv | 87 ++++++++
 tb/tb_inv_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// Shared definitions for the inverter/negator pipeline: operand modes and
// the width-agnostic result function used by the first pipeline stage.
package inv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NOT  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_NEGS = 2'b11
    } mode_e;

    // Returns {ovf, result}; only the low 'width' result bits are meaningful.
    function automatic logic [32:0] inv_compute(
        input logic [31:0] operand,
        input int unsigned width,
        input mode_e       mode
    );
        logic [63:0] mask_wide;
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] x;
        logic [31:0] neg;
        logic [31:0] res;
        logic        ovf;
        mask_wide = (64'd1 << width) - 64'd1;
        mask      = mask_wide[31:0];
        msb       = 32'd1 << (width - 1);
        x         = operand & mask;
        neg       = (~x + 32'd1) & mask;
        res       = x;
        ovf       = 1'b0;
        case (mode)
            MODE_PASS: res = x;
            MODE_NOT:  res = ~x & mask;
            MODE_NEG: begin
                res = neg;
                ovf = (x == msb);
            end
            MODE_NEGS: begin
                // The most-negative value has no positive twin; clamp to max.
                ovf = (x == msb);
                res = ovf ? (msb - 32'd1) : neg;
            end
            default: res = x;
        endcase
        return {ovf, res};
    endfunction

endpackage

// File: rtl/inv_stage.sv
// One pipeline slot: valid/data/ovf register that loads whenever the
// surrounding ready chain says this slot may advance.
module inv_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_ovf,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_ovf
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ovf   <= 1'b0;
        end else if (adv) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_ovf   <= d_ovf;
        end
    end

endmodule

// File: rtl/inv_pipe.sv
// Pipelined pass/NOT/negate/saturating-negate operand preparation with full
// valid/ready back-pressure and a completed-transfer counter.
module inv_pipe
    import inv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] xfer_count
);

    logic [32:0]      calc;
    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_ovf;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0] st_data [STAGES];
    logic [CNT_W-1:0] cnt_reg;
    logic             out_fire;

    assign calc = inv_compute(32'(in_data), 32'(WIDTH), mode_e'(in_mode));

    if (WIDTH < 32) begin : g_unused
        logic unused_calc_bits;
        assign unused_calc_bits = ^calc[31:WIDTH];
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             d_valid;
        logic [WIDTH-1:0] d_data;
        logic             d_ovf;

        if (gi == 0) begin : g_first
            assign d_valid = in_valid;
            assign d_data  = calc[WIDTH-1:0];
            assign d_ovf   = calc[32];
        end else begin : g_rest
            assign d_valid = st_valid[gi-1];
            assign d_data  = st_data[gi-1];
            assign d_ovf   = st_ovf[gi-1];
        end

        // A slot may move when the sink is taking data or any slot from here
        // to the output is empty; flattened to avoid a combinational chain.
        assign adv[gi] = out_ready || !(&st_valid[STAGES-1:gi]);

        inv_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv     (adv[gi]),
            .d_valid (d_valid),
            .d_data  (d_data),
            .d_ovf   (d_ovf),
            .q_valid (st_valid[gi]),
            .q_data  (st_data[gi]),
            .q_ovf   (st_ovf[gi])
        );
    end

    assign in_ready  = !st_valid[0] || adv[0];
    assign out_valid = st_valid[STAGES-1];
    assign out_data  = st_data[STAGES-1];
    assign out_ovf   = st_ovf[STAGES-1];
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (out_fire) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign xfer_count = cnt_reg;

endmodule

// File: tb/tb_inv_pipe.sv
// Scoreboard bench for inv_pipe (WIDTH=8, STAGES=2): drivers push expected
// results on accepted inputs, a negedge monitor pops and compares outputs.
module tb_inv_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic [7:0]   xfer_count;

    typedef struct {
        logic [7:0] d;
        logic       o;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         xfers = 0;
    bit         lat_check = 0;
    bit         rand_done = 0;
    logic [7:0] cur_exp_d = 8'h00;
    logic       cur_exp_o = 1'b0;

    inv_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] d, input logic [1:0] m);
        logic [7:0] n;
        n = 8'h00 - d;
        case (m)
            2'd0:    return {1'b0, d};
            2'd1:    return {1'b0, ~d};
            2'd2:    return {d == 8'h80, n};
            default: return (d == 8'h80) ? {1'b1, 8'h7F} : {1'b0, n};
        endcase
    endfunction

    // Monitor: everything sampled at negedge reflects the upcoming posedge.
    initial begin
        exp_t       e;
        bit         stalled = 0;
        logic [7:0] prev_d = 8'h00;
        logic       prev_o = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0;
            end else begin
                check("xfer_count", 32'(xfer_count), 32'(xfers[7:0]));
                if (stalled && out_valid) begin
                    check("stall_data", 32'(out_data), 32'(prev_d));
                    check("stall_ovf", 32'(out_ovf), 32'(prev_o));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(1), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(e.d));
                        check("out_ovf", 32'(out_ovf), 32'(e.o));
                        if (lat_check) check("latency", 32'(cyc - e.cyc), 32'(S));
                    end
                    xfers++;
                end
                stalled = out_valid && !out_ready;
                prev_d  = out_data;
                prev_o  = out_ovf;
                if (in_valid && in_ready) begin
                    e.d = cur_exp_d;
                    e.o = cur_exp_o;
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] ed, input logic eo);
        int t;
        bit acc;
        t = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        cur_exp_d = ed;
        cur_exp_o = eo;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 300);
        if (!acc) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        logic [8:0] r;

        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_ovf", 32'(out_ovf), 32'(0));
        check("rst_xfer_count", 32'(xfer_count), 32'(0));
        reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'(0));

        // Back-to-back directed stream with latency checking.
        lat_check = 1;
        send(8'h0F, 2'd1, 8'hF0, 1'b0);
        send(8'h05, 2'd2, 8'hFB, 1'b0);
        send(8'h00, 2'd2, 8'h00, 1'b0);
        send(8'h12, 2'd0, 8'h12, 1'b0);
        drain();
        check("stream_xfer_count", 32'(xfer_count), 32'(4));

        send(8'h80, 2'd2, 8'h80, 1'b1);
        send(8'h80, 2'd3, 8'h7F, 1'b1);
        send(8'h81, 2'd3, 8'h7F, 1'b0);
        send(8'h7F, 2'd2, 8'h81, 1'b0);
        send(8'h00, 2'd3, 8'h00, 1'b0);
        send(8'h01, 2'd3, 8'hFF, 1'b0);
        drain();
        lat_check = 0;
        check("ovf_xfer_count", 32'(xfer_count), 32'(10));

        // Back-pressure: fill both slots, stall, then pop and push together.
        out_ready = 1'b0;
        send(8'h33, 2'd1, 8'hCC, 1'b0);
        send(8'h01, 2'd2, 8'hFF, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h44;
        in_mode   = 2'd0;
        cur_exp_d = 8'h44;
        cur_exp_o = 1'b0;
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_out_valid", 32'(out_valid), 32'(1));
        check("full_out_data", 32'(out_data), 32'(8'hCC));
        repeat (2) @(negedge clk);
        check("full_still_stalled", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_push_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("bp_xfer_count", 32'(xfer_count), 32'(13));

        // Randomised valid/ready traffic.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    d = (i % 50 == 7) ? 8'h80 : 8'($urandom_range(0, 255));
                    m = 2'($urandom_range(0, 3));
                    r = model(d, m);
                    send(d, m, r[7:0], r[8]);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_xfer_count", 32'(xfer_count), 32'((13 + 1000) % 256));

        // Reset with two operands in flight.
        out_ready = 1'b0;
        send(8'h21, 2'd1, 8'hDE, 1'b0);
        send(8'h22, 2'd2, 8'hDE, 1'b0);
        @(negedge clk);
        check("pre_reset_out_valid", 32'(out_valid), 32'(1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        xfers = 0;
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'(0));
        check("mid_reset_xfer_count", 32'(xfer_count), 32'(0));
        check("mid_reset_out_data", 32'(out_data), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_reset_out_valid", 32'(out_valid), 32'(0));
        end
        check("post_reset_in_ready", 32'(in_ready), 32'(1));
        check("post_reset_xfer_count", 32'(xfer_count), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
